// File: rtl/lpgbt_uplink_link_ctrl_pkg.sv
// Shared definitions for the lpGBT uplink link controller: state codes and
// default timing, also used by the AXI status-register mapping.
package lpgbt_ctrl_pkg;

    typedef enum logic [2:0] {
        LPGBT_IDLE      = 3'd0,
        LPGBT_RST       = 3'd1,
        LPGBT_WAIT_LOCK = 3'd2,
        LPGBT_UP        = 3'd3,
        LPGBT_RETRY     = 3'd4,
        LPGBT_FAIL      = 3'd5
    } lpgbt_state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 40000;
    localparam int DEF_STABLE_CYCLES = 256;
    localparam int DEF_MAX_RETRIES   = 8;
    localparam int DEF_CNT_WIDTH     = 16;

    // Counter width for a terminal count of n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lpgbt_uplink_link_ctrl_if.sv
// Signals between the link controller and the lpGBT-FPGA uplink core / MGT.
interface lpgbt_uplink_link_ctrl_if;
    logic mgt_rx_rdy_i;
    logic uplinkrdy_i;
    logic uplinkFEC_i;
    logic uplinkRst_o;
    logic mgt_rxpolarity_o;

    modport master (
        input  mgt_rx_rdy_i,
        input  uplinkrdy_i,
        input  uplinkFEC_i,
        output uplinkRst_o,
        output mgt_rxpolarity_o
    );

    modport slave (
        output mgt_rx_rdy_i,
        output uplinkrdy_i,
        output uplinkFEC_i,
        input  uplinkRst_o,
        input  mgt_rxpolarity_o
    );
endinterface

// File: rtl/lpgbt_uplink_link_ctrl_sat_counter.sv
// Saturating status counter; clear has priority over increment.
module lpgbt_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {CNT_WIDTH{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/lpgbt_uplink_link_ctrl.sv
// Uplink bring-up/supervision FSM: reset sequencing, lock wait with retry and
// polarity flipping, plus lock-loss / FEC / retry status counters.
module lpgbt_uplink_link_ctrl
    import lpgbt_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH
) (
    input  logic                       clk40_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic                       auto_polarity_i,
    input  logic                       polarity_init_i,
    input  logic                       clear_cnt_i,
    lpgbt_uplink_link_ctrl_if.master   core,
    output logic                       link_up_o,
    output logic                       fail_o,
    output logic [2:0]                 state_o,
    output logic [CNT_WIDTH-1:0]       retry_cnt_o,
    output logic [CNT_WIDTH-1:0]       lock_loss_cnt_o,
    output logic [CNT_WIDTH-1:0]       fec_cnt_o
);

    localparam logic [2:0] ST_IDLE      = LPGBT_IDLE;
    localparam logic [2:0] ST_RST       = LPGBT_RST;
    localparam logic [2:0] ST_WAIT_LOCK = LPGBT_WAIT_LOCK;
    localparam logic [2:0] ST_UP        = LPGBT_UP;
    localparam logic [2:0] ST_RETRY     = LPGBT_RETRY;
    localparam logic [2:0] ST_FAIL      = LPGBT_FAIL;

    localparam int RW = cnt_w(RST_CYCLES);
    localparam int TW = cnt_w(LOCK_TIMEOUT);
    localparam int SW = cnt_w(STABLE_CYCLES);

    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

    logic [2:0]    state, state_nxt;
    logic [RW-1:0] rst_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] stab_cnt;
    logic          uplink_rst_q;
    logic          polarity_q;
    logic          rdy;
    logic          retry_last;
    logic          retry_inc, retry_clr;
    logic          loss_inc, fec_inc;

    assign rdy        = core.mgt_rx_rdy_i & core.uplinkrdy_i;
    assign retry_last = (32'(retry_cnt_o) + 32'd1) == 32'(MAX_RETRIES);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      state_nxt = ST_RST;
            ST_RST:       if (rst_cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                // A stable lock on the timeout cycle still counts as a lock.
                if (rdy && (stab_cnt == STAB_LAST))
                    state_nxt = ST_UP;
                else if (tmo_cnt == TMO_LAST)
                    state_nxt = ST_RETRY;
            end
            ST_UP:        if (!rdy) state_nxt = ST_RST;
            ST_RETRY:     state_nxt = retry_last ? ST_FAIL : ST_RST;
            ST_FAIL:      state_nxt = ST_FAIL;
            default:      state_nxt = ST_IDLE;
        endcase
        if (!enable_i)
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk40_i or posedge rst_i) begin
        if (rst_i) begin
            rst_cnt  <= '0;
            tmo_cnt  <= '0;
            stab_cnt <= '0;
        end else begin
            rst_cnt <= (state == ST_RST) ? rst_cnt + 1'b1 : '0;
            if (state == ST_WAIT_LOCK) begin
                tmo_cnt  <= tmo_cnt + 1'b1;
                stab_cnt <= rdy ? stab_cnt + 1'b1 : '0;
            end else begin
                tmo_cnt  <= '0;
                stab_cnt <= '0;
            end
        end
    end

    // Outputs are decoded from the next state so they change together with state_o.
    always_ff @(posedge clk40_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            uplink_rst_q <= 1'b1;
            polarity_q   <= 1'b0;
            link_up_o    <= 1'b0;
            fail_o       <= 1'b0;
        end else begin
            state        <= state_nxt;
            uplink_rst_q <= !((state_nxt == ST_WAIT_LOCK) || (state_nxt == ST_UP));
            link_up_o    <= (state_nxt == ST_UP);
            fail_o       <= (state_nxt == ST_FAIL);
            if ((state == ST_IDLE) || (state_nxt == ST_IDLE))
                polarity_q <= polarity_init_i;
            else if ((state == ST_RETRY) && auto_polarity_i)
                polarity_q <= ~polarity_q;
        end
    end

    assign state_o               = state;
    assign core.uplinkRst_o      = uplink_rst_q;
    assign core.mgt_rxpolarity_o = polarity_q;

    assign retry_inc = (state == ST_RETRY) && enable_i;
    assign retry_clr = clear_cnt_i
                     || ((state == ST_IDLE) && enable_i)
                     || ((state != ST_UP) && (state_nxt == ST_UP));
    assign loss_inc  = (state == ST_UP) && enable_i && !rdy;
    assign fec_inc   = (state == ST_UP) && core.uplinkFEC_i;

    lpgbt_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_retry_cnt (
        .clk (clk40_i),
        .rst (rst_i),
        .inc (retry_inc),
        .clr (retry_clr),
        .cnt (retry_cnt_o)
    );

    lpgbt_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_loss_cnt (
        .clk (clk40_i),
        .rst (rst_i),
        .inc (loss_inc),
        .clr (clear_cnt_i),
        .cnt (lock_loss_cnt_o)
    );

    lpgbt_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_fec_cnt (
        .clk (clk40_i),
        .rst (rst_i),
        .inc (fec_inc),
        .clr (clear_cnt_i),
        .cnt (fec_cnt_o)
    );

endmodule

// File: tb/tb_lpgbt_uplink_link_ctrl.sv
// Directed bench for lpgbt_uplink_link_ctrl with small timing parameters.
module tb_lpgbt_uplink_link_ctrl;

    localparam int CW = 4;

    logic          clk40_i = 1'b0;
    logic          rst_i;
    logic          enable_i, auto_polarity_i, polarity_init_i, clear_cnt_i;
    logic          link_up_o, fail_o;
    logic [2:0]    state_o;
    logic [CW-1:0] retry_cnt_o, lock_loss_cnt_o, fec_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    lpgbt_uplink_link_ctrl_if core_if ();

    lpgbt_uplink_link_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (3),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk40_i         (clk40_i),
        .rst_i           (rst_i),
        .enable_i        (enable_i),
        .auto_polarity_i (auto_polarity_i),
        .polarity_init_i (polarity_init_i),
        .clear_cnt_i     (clear_cnt_i),
        .core            (core_if.master),
        .link_up_o       (link_up_o),
        .fail_o          (fail_o),
        .state_o         (state_o),
        .retry_cnt_o     (retry_cnt_o),
        .lock_loss_cnt_o (lock_loss_cnt_o),
        .fec_cnt_o       (fec_cnt_o)
    );

    always #5 clk40_i = ~clk40_i;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk40_i);
    endtask

    task automatic set_rdy(input logic v);
        core_if.mgt_rx_rdy_i = v;
        core_if.uplinkrdy_i  = v;
    endtask

    initial begin
        rst_i = 1'b1; enable_i = 1'b0; auto_polarity_i = 1'b0;
        polarity_init_i = 1'b0; clear_cnt_i = 1'b0;
        set_rdy(1'b0); core_if.uplinkFEC_i = 1'b0;

        // reset values
        step(1);
        chk("rst_state",   state_o, 0);
        chk("rst_uplrst",  core_if.uplinkRst_o, 1);
        chk("rst_linkup",  link_up_o, 0);
        chk("rst_fail",    fail_o, 0);
        chk("rst_pol",     core_if.mgt_rxpolarity_o, 0);
        chk("rst_cnts",    {retry_cnt_o, lock_loss_cnt_o, fec_cnt_o}, 0);
        rst_i = 1'b0;
        step(1);

        // clean lock
        enable_i = 1'b1; set_rdy(1'b1);
        step(1);
        chk("cl_rst_state", state_o, 1);
        step(3);
        chk("cl_rst_last",  {state_o, core_if.uplinkRst_o}, {3'd1, 1'b1});
        step(1);
        chk("cl_wait",      {state_o, core_if.uplinkRst_o}, {3'd2, 1'b0});
        step(7);
        chk("cl_wait_last", {state_o, link_up_o}, {3'd2, 1'b0});
        step(1);
        chk("cl_up",        {state_o, link_up_o}, {3'd3, 1'b1});
        chk("cl_retry",     retry_cnt_o, 0);

        // enable drop in UP
        enable_i = 1'b0;
        step(1);
        chk("en_drop",      {state_o, link_up_o, core_if.uplinkRst_o}, {3'd0, 1'b0, 1'b1});

        // glitch during stability
        enable_i = 1'b1;
        step(5);
        chk("gl_wait",      state_o, 2);
        step(5);
        core_if.uplinkrdy_i = 1'b0;
        step(1);
        core_if.uplinkrdy_i = 1'b1;
        step(7);
        chk("gl_not_yet",   {state_o, link_up_o}, {3'd2, 1'b0});
        step(1);
        chk("gl_up",        {state_o, link_up_o}, {3'd3, 1'b1});
        chk("gl_retry",     retry_cnt_o, 0);

        // lock loss
        core_if.uplinkrdy_i = 1'b0;
        step(1);
        core_if.uplinkrdy_i = 1'b1;
        chk("ll_state",     {state_o, link_up_o}, {3'd1, 1'b0});
        chk("ll_cnt",       lock_loss_cnt_o, 1);
        step(12);
        chk("ll_relock",    state_o, 3);
        chk("ll_retry",     {retry_cnt_o, lock_loss_cnt_o}, {4'd0, 4'd1});

        // FEC saturation and clear
        core_if.uplinkFEC_i = 1'b1;
        step(14);
        chk("fec_14",       fec_cnt_o, 14);
        step(6);
        chk("fec_sat",      fec_cnt_o, 15);
        clear_cnt_i = 1'b1;
        step(1);
        clear_cnt_i = 1'b0;
        chk("fec_clr",      {fec_cnt_o, lock_loss_cnt_o}, 0);
        step(1);
        chk("fec_after",    fec_cnt_o, 1);
        core_if.uplinkFEC_i = 1'b0;

        // timeout with auto polarity
        enable_i = 1'b0;
        step(1);
        auto_polarity_i = 1'b1; polarity_init_i = 1'b0; set_rdy(1'b0);
        enable_i = 1'b1;
        step(5);
        chk("to_a1",        {state_o, core_if.mgt_rxpolarity_o}, {3'd2, 1'b0});
        step(99);
        chk("to_a1_last",   state_o, 2);
        step(1);
        chk("to_retry1",    {state_o, core_if.uplinkRst_o, retry_cnt_o}, {3'd4, 1'b1, 4'd0});
        step(1);
        chk("to_rst2",      {state_o, retry_cnt_o}, {3'd1, 4'd1});
        step(4);
        chk("to_a2",        {state_o, core_if.mgt_rxpolarity_o}, {3'd2, 1'b1});
        step(101);
        chk("to_rst3",      {state_o, retry_cnt_o}, {3'd1, 4'd2});
        step(4);
        chk("to_a3",        {state_o, core_if.mgt_rxpolarity_o}, {3'd2, 1'b0});
        step(101);
        chk("to_fail",      {state_o, fail_o, core_if.uplinkRst_o, retry_cnt_o},
                            {3'd5, 1'b1, 1'b1, 4'd3});
        step(3);
        chk("to_fail_hold", {state_o, fail_o}, {3'd5, 1'b1});
        enable_i = 1'b0;
        step(1);
        chk("to_idle",      {state_o, fail_o, core_if.mgt_rxpolarity_o, retry_cnt_o},
                            {3'd0, 1'b0, 1'b0, 4'd3});

        // async reset mid-WAIT_LOCK
        auto_polarity_i = 1'b0; polarity_init_i = 1'b1;
        enable_i = 1'b1;
        step(1);
        chk("ar_rst",       {state_o, core_if.mgt_rxpolarity_o, retry_cnt_o}, {3'd1, 1'b1, 4'd0});
        step(4);
        chk("ar_wait",      {state_o, core_if.uplinkRst_o}, {3'd2, 1'b0});
        #2 rst_i = 1'b1;
        #1;
        chk("ar_state",     {state_o, core_if.uplinkRst_o, link_up_o, fail_o}, {3'd0, 1'b1, 1'b0, 1'b0});
        chk("ar_pol_cnt",   {core_if.mgt_rxpolarity_o, retry_cnt_o, lock_loss_cnt_o, fec_cnt_o}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lpgbt_uplink_link_ctrl.md
Name: lpgbt_uplink_link_ctrl

Overview:
- Bring-up and supervision controller for the lpGBT-FPGA uplink core. Runs in the recovered 40 MHz user-clock domain.
- Sequences the uplink reset, waits for MGT-ready and uplink-ready, retries on timeout and optionally flips RX polarity between retries.
- Supervises the locked link: counts lock losses and FEC-corrected frames.
- Control and status fields are exposed to the AXI register file through existing CDC structures.

Parameters:
- RST_CYCLES, 16, cycles uplinkRst_o is held high per reset attempt (≥1).
- LOCK_TIMEOUT, 40000, cycles allowed in WAIT_LOCK before a retry (1 ms at 40 MHz).
- STABLE_CYCLES, 256, consecutive cycles mgt_rx_rdy_i && uplinkrdy_i must hold to declare link up.
- MAX_RETRIES, 8, failed attempts before entering FAIL (≥1).
- CNT_WIDTH, 16, width of the saturating status counters.

Ports:
- clk40_i  in  1  40 MHz uplink user clock.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  level; 1 = run bring-up, 0 = hold link in reset (IDLE).
- auto_polarity_i  in  1  1 = toggle polarity on each retry.
- polarity_init_i  in  1  polarity loaded while in IDLE.
- clear_cnt_i  in  1  single-cycle pulse; clears all counters.
- mgt_rx_rdy_i  in  1  MGT receiver ready.
- uplinkrdy_i  in  1  uplink frame-aligned/ready.
- uplinkFEC_i  in  1  FEC correction flag for the current frame.
- uplinkRst_o  out  1  uplink reset to the core.
- mgt_rxpolarity_o  out  1  RX polarity to the MGT.
- link_up_o  out  1  1 while in UP.
- fail_o  out  1  1 while in FAIL.
- state_o  out  3  current state code.
- retry_cnt_o  out  CNT_WIDTH  failed attempts since last UP, saturating.
- lock_loss_cnt_o  out  CNT_WIDTH  UP→loss events, saturating.
- fec_cnt_o  out  CNT_WIDTH  cycles in UP with uplinkFEC_i=1, saturating.

Behaviour:
- Clocking and outputs:
  - All outputs are registered.
  - Reset values: uplinkRst_o=1; all other outputs 0; state_o=IDLE.
- State codes: IDLE=0, RST=1, WAIT_LOCK=2, UP=3, RETRY=4, FAIL=5.
- Global priority: enable_i=0 in any state → IDLE on the next edge. This wins over every other transition.
- IDLE:
  - uplinkRst_o=1; mgt_rxpolarity_o loads polarity_init_i every cycle.
  - enable_i=1 → RST; clears retry_cnt_o.
- RST:
  - uplinkRst_o=1 for exactly RST_CYCLES cycles in RST.
  - Then → WAIT_LOCK; uplinkRst_o=0 in the same cycle state_o reads 2.
- WAIT_LOCK:
  - Timeout timer counts from 0.
  - Stable counter increments while mgt_rx_rdy_i && uplinkrdy_i, and resets to 0 whenever either is low.
  - Stable counter reaching STABLE_CYCLES-1 with both still high → UP.
  - Otherwise, timer reaching LOCK_TIMEOUT-1 → RETRY.
  - Stability wins if both occur in the same cycle.
- RETRY (exactly one cycle):
  - uplinkRst_o=1; retry_cnt_o increments.
  - If auto_polarity_i, mgt_rxpolarity_o toggles.
  - Incremented count == MAX_RETRIES → FAIL, else → RST.
- UP:
  - link_up_o=1; retry_cnt_o cleared on entry.
  - fec_cnt_o increments each cycle uplinkFEC_i=1.
  - mgt_rx_rdy_i=0 or uplinkrdy_i=0 for one cycle → lock_loss_cnt_o increments and → RST. retry_cnt_o is not incremented on this path.
- FAIL:
  - uplinkRst_o=1, fail_o=1.
  - Exits only via enable_i=0 → IDLE.
- Counters:
  - Saturate at 2^CNT_WIDTH-1; no wrap.
  - clear_cnt_i clears all three counters and wins over a simultaneous increment.
  - Counters are not cleared by enable_i changes, except retry_cnt_o as stated above.
- Timers: internal timer widths are $clog2 of their parameters.
- Asynchronous reset mid-operation: immediate return to reset values. Polarity returns to 0 until the next IDLE load.
- Polarity is held constant in RST, WAIT_LOCK and UP; it changes only in IDLE and RETRY.

Decomposition:
- Package lpgbt_ctrl_pkg holds:
  - state enum (3-bit) and its codes;
  - default timing constants (RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  - shared with the AXI status-register mapping.
- One sub-module: lpgbt_sat_counter (CNT_WIDTH, inc, clr, clr-priority, saturating). Instantiated three times.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=3, CNT_WIDTH=4.
- Clean lock: enable_i=1, both ready high from start → uplinkRst_o high 4 cycles, low at WAIT_LOCK entry; link_up_o=1 after 8 stable cycles; retry_cnt_o=0.
- Glitch during stability: ready drops at stable count 5, then recovers → stable count restarts; link_up_o rises 8 cycles after recovery; no retry.
- Timeout with auto polarity: ready never asserted, auto_polarity_i=1, polarity_init_i=0 → polarity sequence 0→1→0; after 3 RETRY cycles fail_o=1, state_o=5, retry_cnt_o=3, uplinkRst_o=1. enable_i=0 → IDLE, polarity=0.
- Lock loss: in UP drop uplinkrdy_i one cycle → lock_loss_cnt_o=1, state RST, link re-locks, retry_cnt_o unchanged (0).
- FEC saturation and clear: in UP hold uplinkFEC_i=1 for 20 cycles → fec_cnt_o=15. clear_cnt_i together with uplinkFEC_i=1 → fec_cnt_o=0 next cycle.
- Async reset and enable drop: assert rst_i mid-WAIT_LOCK → outputs immediately at reset values. Deassert enable_i in UP → IDLE next edge, link_up_o=0, uplinkRst_o=1.
